// File: rtl/mem_burst_if.sv
// mem_burst_if
//   Request, write and read channels of the mem_burst scratchpad, bundled so
//   the memory and its client share one connection.
//   slave  : memory side (mem_burst)
//   master : client side (PE array sequencer, testbench)
//   Signals:
//     req_valid/req_ready/req_we/req_addr/req_len  burst request handshake
//     wr_valid/wr_ready/wr_data                    write beat channel
//     rd_valid/rd_data/rd_last                     read beat channel
//     busy, wrapped                                status
interface mem_burst_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;
    logic              wrapped;

    modport slave (
        input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_data, rd_last, busy, wrapped
    );

    modport master (
        output req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_last, busy, wrapped
    );
endinterface

// File: rtl/mem_burst.sv
// mem_burst
//   Single-port burst scratchpad for the near-memory CNN datapath. Accepts a
//   burst request in IDLE, then streams req_len+1 write beats in (stallable
//   through wr_valid) or req_len+1 read beats out back-to-back, with the
//   address auto-incrementing modulo 2**ADDR_W. Read latency is 1 or 2 cycles.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset (array contents are kept)
//     bus  mem_burst_if.slave: request, write and read channels plus status
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | req_ready high, waiting for a burst request
//   S_WRITE | wr_ready high, one word written per cycle with wr_valid
//   S_READ  | one array read issued per cycle, no stalls
//   S_DRAIN | read pipeline emptying, READ_LAT cycles
module mem_burst #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int LEN_W    = 4,
    parameter int READ_LAT = 1
) (
    input logic       clk,
    input logic       rst,
    mem_burst_if.slave bus
);

    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("mem_burst: READ_LAT must be 1 or 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  beats_left;   // down-counter, last beat when zero
    logic              drain_cnt;    // down-counter, leave DRAIN when zero
    logic              req_ready_r;
    logic              wr_ready_r;
    logic              busy_r;
    logic              wrapped_r;

    logic              rd_v1;
    logic              rd_l1;
    logic [DATA_W-1:0] rd_d1;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_addr    <= '0;
            beats_left  <= '0;
            drain_cnt   <= 1'b0;
            req_ready_r <= 1'b1;
            wr_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            wrapped_r   <= 1'b0;
            rd_v1       <= 1'b0;
            rd_l1       <= 1'b0;
            rd_d1       <= '0;
        end else begin
            rd_v1 <= 1'b0;
            rd_l1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        cur_addr    <= bus.req_addr;
                        beats_left  <= bus.req_len;
                        wrapped_r   <= 1'b0;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (bus.req_we) begin
                            state      <= S_WRITE;
                            wr_ready_r <= 1'b1;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.wr_valid) begin
                        cur_addr <= cur_addr + 1'b1;
                        if (cur_addr == '1) wrapped_r <= 1'b1;
                        if (beats_left == '0) begin
                            state       <= S_IDLE;
                            wr_ready_r  <= 1'b0;
                            req_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                S_READ: begin
                    rd_v1    <= 1'b1;
                    rd_l1    <= (beats_left == '0);
                    rd_d1    <= mem[cur_addr];
                    cur_addr <= cur_addr + 1'b1;
                    if (cur_addr == '1) wrapped_r <= 1'b1;
                    if (beats_left == '0) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'(READ_LAT - 1);
                    end else begin
                        beats_left <= beats_left - 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Returning to IDLE coincides with the last beat leaving
                    // the pipeline, so busy also covers in-flight read data.
                    if (drain_cnt == 1'b0) begin
                        state       <= S_IDLE;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    req_ready_r <= 1'b1;
                    wr_ready_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Array is not reset; a write is dropped in the cycle reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && state == S_WRITE && bus.wr_valid) begin
            mem[cur_addr] <= bus.wr_data;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic              rd_v2;
        logic              rd_l2;
        logic [DATA_W-1:0] rd_d2;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_v2 <= 1'b0;
                rd_l2 <= 1'b0;
                rd_d2 <= '0;
            end else begin
                rd_v2 <= rd_v1;
                rd_l2 <= rd_l1;
                if (rd_v1) rd_d2 <= rd_d1;   // hold last beat while idle
            end
        end

        assign bus.rd_valid = rd_v2;
        assign bus.rd_last  = rd_l2;
        assign bus.rd_data  = rd_d2;
    end else begin : g_lat1
        assign bus.rd_valid = rd_v1;
        assign bus.rd_last  = rd_l1;
        assign bus.rd_data  = rd_d1;
    end

    assign bus.req_ready = req_ready_r;
    assign bus.wr_ready  = wr_ready_r;
    assign bus.busy      = busy_r;
    assign bus.wrapped   = wrapped_r;

endmodule

// File: tb/tb_mem_burst.sv
// tb_mem_burst
//   Drives identical burst traffic into two mem_burst instances (READ_LAT=1
//   and READ_LAT=2). A word-array model predicts every read beat; expected
//   beats, with the clock edge they must appear after, are queued per
//   instance and a monitor pops them whenever rd_valid is seen.
//   Edge numbering: cyc becomes k at posedge k. A request whose handshake is
//   sampled at posedge T delivers beat i right after posedge T+READ_LAT+i.
module tb_mem_burst;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [3:0]  req_len = '0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] mdl [256];
    beat_t       q [2][$];

    logic [1:0]  rv, rl, rr, wrr, bsy, wrp;
    logic [31:0] rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_burst_if #(.DATA_W(32), .ADDR_W(8), .LEN_W(4)) b1 ();
    mem_burst_if #(.DATA_W(32), .ADDR_W(8), .LEN_W(4)) b2 ();

    assign b1.req_valid = req_valid;
    assign b1.req_we    = req_we;
    assign b1.req_addr  = req_addr;
    assign b1.req_len   = req_len;
    assign b1.wr_valid  = wr_valid;
    assign b1.wr_data   = wr_data;
    assign b2.req_valid = req_valid;
    assign b2.req_we    = req_we;
    assign b2.req_addr  = req_addr;
    assign b2.req_len   = req_len;
    assign b2.wr_valid  = wr_valid;
    assign b2.wr_data   = wr_data;

    assign rv  = {b2.rd_valid, b1.rd_valid};
    assign rl  = {b2.rd_last, b1.rd_last};
    assign rr  = {b2.req_ready, b1.req_ready};
    assign wrr = {b2.wr_ready, b1.wr_ready};
    assign bsy = {b2.busy, b1.busy};
    assign wrp = {b2.wrapped, b1.wrapped};
    assign rd[0] = b1.rd_data;
    assign rd[1] = b2.rd_data;

    mem_burst #(.DATA_W(32), .ADDR_W(8), .LEN_W(4), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .bus(b1)
    );
    mem_burst #(.DATA_W(32), .ADDR_W(8), .LEN_W(4), .READ_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .bus(b2)
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lat%0d: got %h required %h (cyc %0d)", nm, k + 1, act, exp, cyc);
        end
    endtask

    // Monitor: sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        beat_t b;
        #2;
        for (int k = 0; k < 2; k++) begin
            if (!rst && rv[k]) begin
                if (q[k].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat lat%0d: got rd_valid with data %h, required no beat (cyc %0d)",
                             k + 1, rd[k], cyc);
                end else begin
                    b = q[k].pop_front();
                    chk("rd_data", k, rd[k], b.data);
                    chk("rd_last", k, 32'(rl[k]), 32'(b.last));
                    chk("beat_edge", k, cyc, b.cyc);
                end
            end
        end
    end

    // All tasks are entered and left just after a falling edge.
    task automatic wait_ready();
        int n = 0;
        while (rr != 2'b11) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL ready_timeout: got req_ready %b, required 11", rr);
                return;
            end
        end
    endtask

    task automatic issue(input bit we, input logic [7:0] addr, input logic [3:0] len, output int t);
        wait_ready();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        t = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 8'($urandom);
        req_len   = 4'($urandom);
        req_we    = 1'($urandom);
        for (int k = 0; k < 2; k++) begin
            chk("req_ready_after_accept", k, 32'(rr[k]), 32'd0);
            chk("busy_after_accept", k, 32'(bsy[k]), 32'd1);
        end
    endtask

    // mode 0: no gaps, 1: random gaps, 2: fixed 1,0,0,1,1,0,1 pattern
    task automatic wr_burst(input logic [7:0] addr, input logic [3:0] len, input int mode,
                            input bit rnd, input logic [31:0] base);
        int t;
        int beats = 0;
        int c = 0;
        bit v;
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        issue(1'b1, addr, len, t);
        for (int k = 0; k < 2; k++) chk("wr_ready_in_write", k, 32'(wrr[k]), 32'd1);
        while (beats <= int'(len)) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 3) != 0) || (c > 40);
                default: v = pat[c % 7];
            endcase
            wr_valid = v;
            wr_data  = v ? (rnd ? $urandom : base + 32'(beats)) : $urandom;
            if (v) begin
                mdl[8'(int'(addr) + beats)] = wr_data;
                beats++;
            end
            @(negedge clk);
            c++;
        end
        for (int k = 0; k < 2; k++) chk("wr_ready_after_burst", k, 32'(wrr[k]), 32'd0);
        // A beat offered after the burst has ended must not be written.
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic rd_burst(input logic [7:0] addr, input logic [3:0] len);
        int t;
        beat_t b;
        issue(1'b0, addr, len, t);
        for (int i = 0; i <= int'(len); i++) begin
            for (int k = 0; k < 2; k++) begin
                b.data = mdl[8'(int'(addr) + i)];
                b.last = (i == int'(len));
                b.cyc  = t + k + 1 + i;
                q[k].push_back(b);
            end
        end
    endtask

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", k, 32'(rr[k]), 32'd1);
            chk("rst_wr_ready", k, 32'(wrr[k]), 32'd0);
            chk("rst_rd_valid", k, 32'(rv[k]), 32'd0);
            chk("rst_rd_last", k, 32'(rl[k]), 32'd0);
            chk("rst_rd_data", k, rd[k], 32'd0);
            chk("rst_busy", k, 32'(bsy[k]), 32'd0);
            chk("rst_wrapped", k, 32'(wrp[k]), 32'd0);
        end

        // known contents everywhere
        for (int blk = 0; blk < 16; blk++) wr_burst(8'(blk * 16), 4'd15, 1, 1'b1, 32'd0);

        // simple write then read back
        wr_burst(8'h10, 4'd3, 0, 1'b0, 32'hA0);
        rd_burst(8'h10, 4'd3);
        wait_ready();
        for (int k = 0; k < 2; k++) chk("wrapped_no_cross", k, 32'(wrp[k]), 32'd0);

        // gapped write, read a window around it to catch stray writes
        wr_burst(8'h10, 4'd3, 2, 1'b0, 32'hB0);
        rd_burst(8'h0E, 4'd7);

        // address wrap
        wr_burst(8'hFE, 4'd3, 0, 1'b0, 32'hC0);
        wait_ready();
        for (int k = 0; k < 2; k++) chk("wrapped_set", k, 32'(wrp[k]), 32'd1);
        rd_burst(8'h20, 4'd1);
        for (int k = 0; k < 2; k++) chk("wrapped_cleared", k, 32'(wrp[k]), 32'd0);
        rd_burst(8'hFE, 4'd3);
        wait_ready();
        for (int k = 0; k < 2; k++) chk("wrapped_read", k, 32'(wrp[k]), 32'd1);

        // full random fill, random-start full-length reads
        for (int blk = 0; blk < 16; blk++) wr_burst(8'(blk * 16), 4'd15, 1, 1'b1, 32'd0);
        for (int n = 0; n < 16; n++) rd_burst(8'($urandom_range(0, 255)), 4'd15);

        // reset in the middle of a read burst
        rd_burst(8'h40, 4'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        q[0].delete();
        q[1].delete();
        for (int k = 0; k < 2; k++) begin
            chk("midrst_rd_valid", k, 32'(rv[k]), 32'd0);
            chk("midrst_req_ready", k, 32'(rr[k]), 32'd1);
            chk("midrst_busy", k, 32'(bsy[k]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        rd_burst(8'h40, 4'd7);

        // random mixed traffic
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1) == 1)
                wr_burst(8'($urandom), 4'($urandom), 1, 1'b1, 32'd0);
            else
                rd_burst(8'($urandom), 4'($urandom));
        end

        wait_ready();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) chk("beats_outstanding", k, 32'(q[k].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, required completion");
        $fatal(1, "timeout");
    end

endmodule
